// File: rtl/udp_pkg.sv
// Shared constants for the UDP receive frame checker.
// Holds the one-hot state encoding, the default expected payload
// ("HELLO,WeareteamHTGZ\n", first byte in the MSBs) and a saturating
// 16-bit increment helper used by the byte and frame counters.
package udp_pkg;

    localparam int unsigned STATE_W = 5;

    // One-hot state encoding
    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 5'b00001,
        S_RECV   = 5'b00010,
        S_CHECK  = 5'b00100,
        S_REPORT = 5'b01000,
        S_DROP   = 5'b10000
    } state_t;

    localparam int unsigned DEF_LEN = 20;
    localparam logic [8*DEF_LEN-1:0] DEF_PATTERN =
        160'h48454C4C4F2C5765617265746561_6D48_54475A0A;

    localparam logic [15:0] IDX_NONE = 16'hFFFF;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/udp_rx_frame_check.sv
// UDP receive payload checker: compares each received byte against a fixed
// expected pattern and reports a per-frame verdict plus running counters.
//
// Optional feature macro: UDP_RX_LEN_CHECK_EN -- when defined, the length
// reported by the receive stack (sampled with byte 0) must also equal the
// received byte count for the frame to pass.
//
// Ports:
//   rgmii_clk            sole clock, rising edge
//   rst                  synchronous active-high reset
//   udp_rec_data_valid   payload byte strobe, one byte per cycle, no gaps
//   udp_rec_rdata        payload byte
//   udp_rec_data_length  payload length from the receive stack
//   frame_done           one-cycle verdict pulse
//   frame_pass           verdict of the last frame
//   frame_len            byte count of the last frame (saturating)
//   first_err_idx        first mismatching byte index, 16'hFFFF if none
//   frame_cnt            total reported frames (saturating)
//   err_cnt              failed frames (saturating)
module udp_rx_frame_check
    import udp_pkg::*;
#(
    parameter int unsigned          EXP_LEN     = DEF_LEN,
    parameter logic [8*EXP_LEN-1:0] EXP_PATTERN = DEF_PATTERN
) (
    input  logic        rgmii_clk,
    input  logic        rst,
    input  logic        udp_rec_data_valid,
    input  logic [7:0]  udp_rec_rdata,
    input  logic [15:0] udp_rec_data_length,
    output logic        frame_done,
    output logic        frame_pass,
    output logic [15:0] frame_len,
    output logic [15:0] first_err_idx,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam int unsigned PAT_W = 8 * EXP_LEN;
    localparam int unsigned IDX_W = (EXP_LEN > 1) ? $clog2(EXP_LEN) : 1;

    state_t      state;
    logic [15:0] byte_cnt;
    logic [15:0] err_idx;
    logic        err_seen;
    logic        pass_q;
    logic        valid_q;

    logic [7:0]  pat_bytes [EXP_LEN];
    logic [15:0] byte_idx_c;
    logic [7:0]  exp_byte_c;
    logic        mismatch_c;
    logic        len_ok_c;

    // Pattern unpacked into bytes, byte 0 taken from the MSBs
    for (genvar g = 0; g < EXP_LEN; g++) begin : g_pat
        assign pat_bytes[g] = EXP_PATTERN[PAT_W-1-8*g -: 8];
    end

    // Byte 0 is consumed in IDLE, where byte_cnt still holds the previous frame
    assign byte_idx_c = (state == S_IDLE) ? 16'd0 : byte_cnt;
    assign exp_byte_c = pat_bytes[byte_idx_c[IDX_W-1:0]];

    // Bytes past the expected length always count as mismatches
    assign mismatch_c = (32'(byte_idx_c) >= EXP_LEN) || (udp_rec_rdata != exp_byte_c);

`ifdef UDP_RX_LEN_CHECK_EN
    logic [15:0] len_q;
    assign len_ok_c = (byte_cnt == len_q);
`else
    logic unused_len;
    assign unused_len = ^udp_rec_data_length;
    assign len_ok_c   = 1'b1;
`endif

    // Frame FSM with registered outputs
    always_ff @(posedge rgmii_clk) begin
        // Tracked through reset so a burst already in flight at reset release is dropped
        valid_q <= udp_rec_data_valid;
        if (rst) begin
            state         <= S_IDLE;
            byte_cnt      <= 16'd0;
            err_idx       <= IDX_NONE;
            err_seen      <= 1'b0;
            pass_q        <= 1'b0;
            frame_done    <= 1'b0;
            frame_pass    <= 1'b0;
            frame_len     <= 16'd0;
            first_err_idx <= IDX_NONE;
            frame_cnt     <= 16'd0;
            err_cnt       <= 16'd0;
`ifdef UDP_RX_LEN_CHECK_EN
            len_q         <= 16'd0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (udp_rec_data_valid) begin
                        if (valid_q) begin
                            state <= S_DROP;
                        end else begin
                            state    <= S_RECV;
                            byte_cnt <= 16'd1;
                            err_seen <= mismatch_c;
                            err_idx  <= mismatch_c ? 16'd0 : IDX_NONE;
`ifdef UDP_RX_LEN_CHECK_EN
                            len_q    <= udp_rec_data_length;
`endif
                        end
                    end
                end
                S_RECV: begin
                    if (udp_rec_data_valid) begin
                        byte_cnt <= sat_inc(byte_cnt);
                        if (mismatch_c && !err_seen) begin
                            err_seen <= 1'b1;
                            err_idx  <= byte_cnt;
                        end
                    end else begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // A saturated count can never equal EXP_LEN, so it fails here
                    pass_q <= (32'(byte_cnt) == EXP_LEN) && !err_seen && len_ok_c;
                    state  <= S_REPORT;
                end
                S_REPORT: begin
                    frame_done    <= 1'b1;
                    frame_pass    <= pass_q;
                    frame_len     <= byte_cnt;
                    first_err_idx <= err_idx;
                    frame_cnt     <= sat_inc(frame_cnt);
                    if (!pass_q) begin
                        err_cnt <= sat_inc(err_cnt);
                    end
                    state <= udp_rec_data_valid ? S_DROP : S_IDLE;
                end
                S_DROP: begin
                    if (!udp_rec_data_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx_frame_check.sv
// Self-checking bench for udp_rx_frame_check (default parameters).
// A frame-level model derives the verdict from the byte list; one compare
// process checks every output on every cycle, and selected frames also
// carry hand-computed literal results.
module tb_udp_rx_frame_check;

`ifdef UDP_RX_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    typedef logic [7:0] bq_t [$];

    typedef struct {
        int unsigned cyc;
        logic        pass;
        logic [15:0] len;
        logic [15:0] idx;
        logic        l_pass;
        logic [15:0] l_len;
        logic [15:0] l_idx;
        logic [15:0] l_fcnt;
        logic [15:0] l_ecnt;
    } exp_t;

    bit          rgmii_clk;
    logic        rst;
    logic        udp_rec_data_valid;
    logic [7:0]  udp_rec_rdata;
    logic [15:0] udp_rec_data_length;
    logic        frame_done;
    logic        frame_pass;
    logic [15:0] frame_len;
    logic [15:0] first_err_idx;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    udp_rx_frame_check dut (
        .rgmii_clk           (rgmii_clk),
        .rst                 (rst),
        .udp_rec_data_valid  (udp_rec_data_valid),
        .udp_rec_rdata       (udp_rec_rdata),
        .udp_rec_data_length (udp_rec_data_length),
        .frame_done          (frame_done),
        .frame_pass          (frame_pass),
        .frame_len           (frame_len),
        .first_err_idx       (first_err_idx),
        .frame_cnt           (frame_cnt),
        .err_cnt             (err_cnt)
    );

    initial forever #5 rgmii_clk = ~rgmii_clk;

    string       pat_s = "HELLO,WeareteamHTGZ\n";
    int unsigned cyc = 0;
    bit          rst_q = 1'b0;
    exp_t        pend [64];
    int unsigned wr_idx = 0;
    int unsigned rd_idx = 0;
    bit          finishing = 1'b0;
    bit          done_flag = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;

    always @(posedge rgmii_clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    function automatic bq_t good_frame();
        bq_t q;
        for (int i = 0; i < pat_s.len(); i++) q.push_back(8'(pat_s[i]));
        return q;
    endfunction

    // Verdict from the frame's bytes alone
    function automatic exp_t model(input bq_t d, input logic [15:0] len);
        exp_t e;
        bit   bad;
        int   n;
        n = d.size();
        bad = 1'b0;
        e.cyc = 0; e.l_pass = 1'b0; e.l_len = '0; e.l_idx = '0; e.l_fcnt = '0; e.l_ecnt = '0;
        e.idx = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            if (i >= pat_s.len() || d[i] != 8'(pat_s[i])) begin
                if (!bad) e.idx = 16'(i);
                bad = 1'b1;
            end
        end
        e.len  = (n > 65535) ? 16'hFFFF : 16'(n);
        e.pass = !bad && (n == pat_s.len()) && (!LEN_CHECK || int'(len) == n);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every output, every cycle
    logic        m_pass;
    logic [15:0] m_len, m_idx, m_fcnt, m_ecnt;
    bit          due;
    exp_t        ce;
    always @(negedge rgmii_clk) begin
        if (rst_q) begin
            m_pass = 1'b0; m_len = 16'd0; m_idx = 16'hFFFF; m_fcnt = 16'd0; m_ecnt = 16'd0;
            rd_idx = wr_idx;
            chk("rst_frame_done", 32'(frame_done), 32'(0));
            chk("rst_frame_pass", 32'(frame_pass), 32'(0));
            chk("rst_frame_len", 32'(frame_len), 32'(0));
            chk("rst_first_err_idx", 32'(first_err_idx), 32'hFFFF);
            chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
            chk("rst_err_cnt", 32'(err_cnt), 32'(0));
        end else begin
            due = (rd_idx != wr_idx) && (pend[rd_idx % 64].cyc == cyc);
            chk("frame_done", 32'(frame_done), 32'(due));
            if (due) begin
                ce = pend[rd_idx % 64];
                rd_idx++;
                m_pass = ce.pass;
                m_len  = ce.len;
                m_idx  = ce.idx;
                m_fcnt = (m_fcnt == 16'hFFFF) ? m_fcnt : m_fcnt + 16'd1;
                if (!ce.pass) m_ecnt = (m_ecnt == 16'hFFFF) ? m_ecnt : m_ecnt + 16'd1;
                chk("lit_frame_pass", 32'(frame_pass), 32'(ce.l_pass));
                chk("lit_frame_len", 32'(frame_len), 32'(ce.l_len));
                chk("lit_first_err_idx", 32'(first_err_idx), 32'(ce.l_idx));
                chk("lit_frame_cnt", 32'(frame_cnt), 32'(ce.l_fcnt));
                chk("lit_err_cnt", 32'(err_cnt), 32'(ce.l_ecnt));
            end else if (rd_idx != wr_idx && pend[rd_idx % 64].cyc < cyc) begin
                rd_idx++;
            end
            chk("frame_pass", 32'(frame_pass), 32'(m_pass));
            chk("frame_len", 32'(frame_len), 32'(m_len));
            chk("first_err_idx", 32'(first_err_idx), 32'(m_idx));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
            chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
            if (finishing && !done_flag) begin
                chk("pending_verdicts", 32'(wr_idx - rd_idx), 32'(0));
                done_flag = 1'b1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge rgmii_clk);
            udp_rec_data_valid = 1'b0;
            udp_rec_rdata = 8'h00;
        end
    endtask

    // Sends a frame; its verdict is due 3 negedges after valid is driven low
    task automatic send_frame(input bq_t d, input logic [15:0] len, input logic lp,
                              input logic [15:0] ll, input logic [15:0] li,
                              input logic [15:0] lf, input logic [15:0] le);
        exp_t e;
        for (int i = 0; i < d.size(); i++) begin
            @(negedge rgmii_clk);
            udp_rec_data_valid = 1'b1;
            udp_rec_rdata = d[i];
            if (i == 0) udp_rec_data_length = len;
        end
        @(negedge rgmii_clk);
        udp_rec_data_valid = 1'b0;
        udp_rec_rdata = 8'h00;
        e = model(d, len);
        e.l_pass = lp; e.l_len = ll; e.l_idx = li; e.l_fcnt = lf; e.l_ecnt = le;
        e.cyc = cyc + 3;
        pend[wr_idx % 64] = e;
        wr_idx++;
    endtask

    task automatic send_burst(input bq_t d);
        for (int i = 0; i < d.size(); i++) begin
            @(negedge rgmii_clk);
            udp_rec_data_valid = 1'b1;
            udp_rec_rdata = d[i];
        end
        @(negedge rgmii_clk);
        udp_rec_data_valid = 1'b0;
        udp_rec_rdata = 8'h00;
    endtask

    initial begin
        bq_t g, f, b;
        rst = 1'b1;
        udp_rec_data_valid = 1'b0;
        udp_rec_rdata = 8'h00;
        udp_rec_data_length = 16'd20;
        repeat (3) @(negedge rgmii_clk);
        rst = 1'b0;
        idle(2);

        g = good_frame();
        send_frame(g, 16'd20, 1'b1, 16'd20, 16'hFFFF, 16'd1, 16'd0);
        idle(5);

        f = good_frame();
        f[5] = 8'h00;
        send_frame(f, 16'd20, 1'b0, 16'd20, 16'd5, 16'd2, 16'd1);
        idle(5);

        f = good_frame();
        f.push_back(8'h41);
        send_frame(f, 16'd21, 1'b0, 16'd21, 16'd20, 16'd3, 16'd2);
        idle(5);

        send_frame(g, 16'd18, LEN_CHECK ? 1'b0 : 1'b1, 16'd20, 16'hFFFF, 16'd4,
                   LEN_CHECK ? 16'd3 : 16'd2);
        idle(5);

        // Reset at byte 10, released with the burst still running
        for (int i = 0; i < 10; i++) begin
            @(negedge rgmii_clk);
            udp_rec_data_valid = 1'b1;
            udp_rec_rdata = g[i];
            if (i == 0) udp_rec_data_length = 16'd20;
        end
        @(negedge rgmii_clk);
        rst = 1'b1;
        udp_rec_rdata = g[10];
        @(negedge rgmii_clk);
        rst = 1'b0;
        udp_rec_rdata = g[11];
        for (int i = 12; i < 20; i++) begin
            @(negedge rgmii_clk);
            udp_rec_rdata = g[i];
        end
        idle(6);
        send_frame(g, 16'd20, 1'b1, 16'd20, 16'hFFFF, 16'd1, 16'd0);
        idle(5);

        // Burst starting in the verdict-computation cycle is dropped
        send_frame(g, 16'd20, 1'b1, 16'd20, 16'hFFFF, 16'd2, 16'd0);
        b = {8'h11, 8'h22, 8'h33};
        send_burst(b);
        idle(5);
        send_frame(g, 16'd20, 1'b1, 16'd20, 16'hFFFF, 16'd3, 16'd0);
        idle(6);

        finishing = 1'b1;
        for (int k = 0; k < 10 && !done_flag; k++) @(negedge rgmii_clk);
        if (!done_flag) begin
            $display("FAIL compare_handshake: got timeout expected completion");
            $fatal(1, "compare process stalled");
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/udp_rx_frame_check.md
UDP_RX_FRAME_CHECK -- requirements
Module: udp_rx_frame_check

Interface
REQ-001 SHALL have parameter EXP_LEN, default 20, meaning the expected UDP payload length in bytes (1..64).
REQ-002 SHALL have parameter EXP_PATTERN, default 160'h48454C4C4F2C5765617265746561 6D48_54475A0A, meaning the expected payload with the first byte in the MSBs (8*EXP_LEN bits used).
REQ-003 SHALL have port rgmii_clk, input, 1, the sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port udp_rec_data_valid, input, 1, high while received payload bytes are presented, one byte per cycle.
REQ-006 SHALL have port udp_rec_rdata, input, 8, received payload byte.
REQ-007 SHALL have port udp_rec_data_length, input, 16, UDP payload length reported by the receive stack.
REQ-008 SHALL have port frame_done, output, 1, one-cycle pulse when the frame verdict is valid.
REQ-009 SHALL have port frame_pass, output, 1, verdict of the last frame, held until the next frame_done.
REQ-010 SHALL have port frame_len, output, 16, byte count of the last frame, saturating at 16'hFFFF.
REQ-011 SHALL have port first_err_idx, output, 16, index of the first mismatching byte of the last frame; 16'hFFFF if none.
REQ-012 SHALL have ports frame_cnt and err_cnt, output, 16 each, counting total frames and failed frames, saturating at 16'hFFFF.

Function
REQ-013 SHALL implement states IDLE, RECV, CHECK, REPORT, DROP.
REQ-014 In IDLE, udp_rec_data_valid=1 SHALL capture byte index 0 and move to RECV.
REQ-015 In RECV, each valid byte at index i SHALL be compared with EXP_PATTERN byte i; any byte with i>=EXP_LEN is a mismatch.
REQ-016 The first mismatch index SHALL be latched, and later mismatches SHALL NOT overwrite it.
REQ-017 The first cycle with udp_rec_data_valid=0 in RECV SHALL move to CHECK; gaps inside a frame are not supported.
REQ-018 CHECK SHALL set pass when the count equals EXP_LEN and no mismatch occurred, then move to REPORT.
REQ-019 REPORT SHALL drive frame_done=1 for one cycle and update frame_pass, frame_len, first_err_idx, frame_cnt (+1), and err_cnt (+1 if fail).
REQ-020 frame_done SHALL rise exactly 2 clocks after the first cycle that valid is sampled low.
REQ-021 Leaving REPORT with udp_rec_data_valid=1 SHALL enter DROP.
REQ-022 DROP SHALL ignore bytes and return to IDLE when valid=0; the dropped frame increments neither counter.
REQ-023 Valid asserted during CHECK SHALL be ignored, and that burst handled as in REQ-021/022.
REQ-024 The byte counter SHALL saturate at 16'hFFFF without wrap, and the frame SHALL still complete with fail.

Reset
REQ-025 On rst=1 at a clock edge, the state SHALL be IDLE and all outputs and counters 0, except first_err_idx=16'hFFFF.
REQ-026 rst mid-frame SHALL abandon the frame with no frame_done.
REQ-027 After rst, if valid is still high, the remainder of that burst SHALL go to DROP.

Configuration
REQ-028 With UDP_RX_LEN_CHECK_EN defined, udp_rec_data_length SHALL be sampled with byte 0, and the frame SHALL fail if the final count differs from it.
REQ-029 Without UDP_RX_LEN_CHECK_EN, udp_rec_data_length SHALL be unused and the verdict SHALL depend only on EXP_LEN and EXP_PATTERN.

Structure
REQ-030 The state encoding constants (one-hot, 5 bits) and the default 20-byte pattern constant SHALL live in a shared udp_pkg package.
REQ-031 No sub-module SHALL be used, and the byte comparator SHALL be inline.

Verification
REQ-032 Scenario: send 20 bytes "HELLO,WeareteamHTGZ\n" with length=20 -> frame_done 2 clocks after valid falls, frame_pass=1, frame_len=20, first_err_idx=FFFF, frame_cnt=1, err_cnt=0.
REQ-033 Scenario: same frame with byte 5 changed to 8'h00 -> frame_pass=0, first_err_idx=5, err_cnt=1.
REQ-034 Scenario: 21 bytes (correct 20 plus 8'h41) -> frame_pass=0, frame_len=21, first_err_idx=20.
REQ-035 Scenario: correct 20 bytes with udp_rec_data_length=18 -> frame_pass=0 with UDP_RX_LEN_CHECK_EN defined, and frame_pass=1 without it.
REQ-036 Scenario: assert rst at byte 10, deassert it with valid still high -> no frame_done, DROP until valid falls, counters 0, next good frame passes.
REQ-037 Scenario: a new burst starts in the CHECK cycle -> it is dropped, frame_cnt increments once, and a following good frame passes.
